// File: rtl/jk_register_arbiter_if.sv
// Request/command/status bundle between N JK requesters and the shared register.
interface jk_register_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] j;
    logic [N*W-1:0] k;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;
    logic [IDW-1:0] gnt_id;

    modport master (
        output req, j, k,
        input  ack, q, busy, gnt_id
    );

    modport slave (
        input  req, j, k,
        output ack, q, busy, gnt_id
    );
endinterface

// File: rtl/jk_register_arbiter.sv
// Shared W-bit JK register behind an N-way req/ack arbiter (round-robin by default).
// Define JK_ARB_FIXED_PRIO_EN to select fixed priority (lowest req index wins, no pointer).
module jk_register_arbiter #(
    parameter int unsigned   N    = 4,
    parameter int unsigned   W    = 8,
    parameter logic [W-1:0]  INIT = '0
) (
    input logic                 clock,
    input logic                 preset_,
    jk_register_arbiter_if.slave bus
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   reg_q,   reg_d;
    logic [N-1:0]   ack_q,   ack_d;
    logic [IDW-1:0] gnt_q,   gnt_d;
    logic           busy_q;

    logic           arb_valid;
    logic [IDW-1:0] arb_g;
    logic [W-1:0]   j_g, k_g;
    logic [IDW-1:0] gnt_next;

`ifdef JK_ARB_FIXED_PRIO_EN
    always_comb begin
        arb_valid = 1'b0;
        arb_g     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!arb_valid && bus.req[i]) begin
                arb_valid = 1'b1;
                arb_g     = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    // Search starts at ptr and wraps; ptr + off is always below 2N, so one subtract wraps it.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        arb_valid = 1'b0;
        arb_g     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= N) idx = idx - N;
            if (!arb_valid && bus.req[idx]) begin
                arb_valid = 1'b1;
                arb_g     = IDW'(idx);
            end
        end
    end
`endif

    assign j_g      = bus.j[gnt_q*W +: W];
    assign k_g      = bus.k[gnt_q*W +: W];
    assign gnt_next = (gnt_q == IDW'(N - 1)) ? '0 : gnt_q + IDW'(1);

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        ack_d   = ack_q;
        gnt_d   = gnt_q;
`ifndef JK_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_g;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                // Committed regardless of whether the requester still holds req.
                reg_d        = (~reg_q & j_g) | (reg_q & ~k_g);
                ack_d        = '0;
                ack_d[gnt_q] = 1'b1;
                state_d      = ACK;
            end
            ACK: begin
                if (!bus.req[gnt_q]) begin
                    ack_d   = '0;
                    state_d = IDLE;
`ifndef JK_ARB_FIXED_PRIO_EN
                    ptr_d   = gnt_next;
`endif
                end
            end
            default: begin
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge preset_) begin
        if (!preset_) begin
            state_q <= IDLE;
            reg_q   <= INIT;
            ack_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
`ifndef JK_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            ack_q   <= ack_d;
            gnt_q   <= gnt_d;
            busy_q  <= (state_d != IDLE);
`ifndef JK_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

`ifdef JK_ARB_FIXED_PRIO_EN
    logic unused_gnt_next;
    assign unused_gnt_next = ^gnt_next;
`endif

    assign bus.ack    = ack_q;
    assign bus.q      = reg_q;
    assign bus.busy   = busy_q;
    assign bus.gnt_id = gnt_q;
endmodule

// File: tb/tb_jk_register_arbiter.sv
// Directed bench for jk_register_arbiter (N=4, W=8); JK_ARB_FIXED_PRIO_EN selects the fixed-priority grant order.
module tb_jk_register_arbiter;
    logic clock = 1'b0;
    logic preset_;
    int   checks = 0;
    int   fails  = 0;

    always #5 clock = ~clock;

    jk_register_arbiter_if #(.N(4), .W(8)) bus ();

    jk_register_arbiter #(.N(4), .W(8), .INIT(8'h00)) dut (
        .clock   (clock),
        .preset_ (preset_),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction from IDLE, releasing req `extra` cycles after ack is first seen.
    task automatic xact(input string tag, input int i, input logic [7:0] jv, input logic [7:0] kv,
                        input logic [7:0] oldq, input logic [7:0] newq, input int extra);
        bus.j[i*8 +: 8] = jv;
        bus.k[i*8 +: 8] = kv;
        bus.req[i]      = 1'b1;
        @(negedge clock);
        chk({tag, "_apply_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_apply_ack"},  32'(bus.ack), 32'd0);
        chk({tag, "_apply_q"},    32'(bus.q), 32'(oldq));
        chk({tag, "_gnt_id"},     32'(bus.gnt_id), 32'(i));
        @(negedge clock);
        chk({tag, "_q"},   32'(bus.q), 32'(newq));
        chk({tag, "_ack"}, 32'(bus.ack), 32'(1) << i);
        for (int c = 0; c < extra; c++) begin
            @(negedge clock);
            chk({tag, "_ack_hold"},  32'(bus.ack), 32'(1) << i);
            chk({tag, "_busy_hold"}, 32'(bus.busy), 32'd1);
        end
        bus.req[i] = 1'b0;
        @(negedge clock);
        chk({tag, "_rel_ack"},  32'(bus.ack), 32'd0);
        chk({tag, "_rel_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_rel_q"},    32'(bus.q), 32'(newq));
    endtask

    initial begin
        logic [7:0] rj [4];
        logic [7:0] rk [4];
        int         order [5];
        logic [7:0] qm;
        logic [3:0] ack_prev;
        int         n, last, reraised;

        preset_  = 1'b0;
        bus.req  = '0;
        bus.j    = '0;
        bus.k    = '0;
        repeat (2) @(negedge clock);
        chk("rst_q",      32'(bus.q), 32'h00);
        chk("rst_ack",    32'(bus.ack), 32'd0);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        preset_ = 1'b1;
        @(negedge clock);

        xact("load_aa", 0, 8'hAA, 8'h00, 8'h00, 8'hAA, 0);
        xact("single",  1, 8'h0F, 8'hF0, 8'hAA, 8'h0F, 1);
        xact("load_3c", 3, 8'h3C, 8'hC3, 8'h0F, 8'h3C, 0);
        xact("toggle",  2, 8'hFF, 8'hFF, 8'h3C, 8'hC3, 0);
        xact("hold",    2, 8'h00, 8'h00, 8'hC3, 8'hC3, 0);

        // Reset in the middle of an ACK phase holding q=5A.
        bus.j[7:0] = 8'h5A;
        bus.k[7:0] = 8'hA5;
        bus.req[0] = 1'b1;
        repeat (2) @(negedge clock);
        chk("pre_rst_q",   32'(bus.q), 32'h5A);
        chk("pre_rst_ack", 32'(bus.ack), 32'd1);
        #2 preset_ = 1'b0;
        #1;
        chk("async_rst_q",    32'(bus.q), 32'h00);
        chk("async_rst_ack",  32'(bus.ack), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_gnt",  32'(bus.gnt_id), 32'd0);
        @(negedge clock);
        bus.req = '0;
        preset_ = 1'b1;
        @(negedge clock);

        xact("fresh0", 0, 8'h11, 8'h00, 8'h00, 8'h11, 0);

        // req[0] withdrawn while the grant is in APPLY.
        bus.j[7:0] = 8'hF0;
        bus.k[7:0] = 8'h01;
        bus.req[0] = 1'b1;
        @(negedge clock);
        chk("early_busy", 32'(bus.busy), 32'd1);
        bus.req[0] = 1'b0;
        @(negedge clock);
        chk("early_q",   32'(bus.q), 32'hF0);
        chk("early_ack", 32'(bus.ack), 32'd1);
        @(negedge clock);
        chk("early_ack_off", 32'(bus.ack), 32'd0);
        chk("early_idle",    32'(bus.busy), 32'd0);

        xact("ptr_wrap", 3, 8'h00, 8'hF0, 8'hF0, 8'h00, 0);

        // All four request; requester 0 re-requests once after its first release.
        rj = '{8'h01, 8'h06, 8'h30, 8'hC0};
        rk = '{8'h00, 8'h02, 8'h10, 8'h01};
`ifdef JK_ARB_FIXED_PRIO_EN
        order = '{0, 0, 1, 2, 3};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            bus.j[i*8 +: 8] = rj[i];
            bus.k[i*8 +: 8] = rk[i];
        end
        bus.req  = 4'b1111;
        qm       = 8'h00;
        ack_prev = '0;
        n        = 0;
        last     = 0;
        reraised = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clock);
            chk("rr_onehot", 32'($onehot0(bus.ack)), 32'd1);
            if (bus.ack != 4'd0 && ack_prev == 4'd0) begin
                qm = (~qm & rj[order[n]]) | (qm & ~rk[order[n]]);
                chk("rr_gnt_id", 32'(bus.gnt_id), 32'(order[n]));
                chk("rr_ack",    32'(bus.ack), 32'(1) << order[n]);
                chk("rr_q",      32'(bus.q), 32'(qm));
                if (n > 0) chk("rr_spacing", 32'(c - last), 32'd3);
                last = c;
                bus.req[order[n]] = 1'b0;
                n++;
            end else if (bus.ack == 4'd0 && ack_prev != 4'd0 && reraised == 0) begin
                bus.req[0] = 1'b1;
                reraised   = 1;
            end
            ack_prev = bus.ack;
        end
        chk("rr_grants", 32'(n), 32'd5);
        @(negedge clock);
        chk("rr_end_ack",  32'(bus.ack), 32'd0);
        chk("rr_end_busy", 32'(bus.busy), 32'd0);
        chk("rr_end_q",    32'(bus.q), 32'(qm));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule

// File: doc/jk_register_arbiter.md
# jk_register_arbiter

Shared W-bit JK register with a round-robin arbiter in front of it. Up to N requesters issue bitwise JK commands (set/clear/toggle/hold masks) over a four-phase req/ack handshake. The block serialises those commands onto one register bank with the same next-state rule as the team's single JK flip-flop. It sits between control FSMs that share a flag/status register and the logic that reads `q`.

## Interface
- `N`, default 4: number of requesters, ≥1.
- `W`, default 8: register width.
- `INIT`, default `{W{1'b0}}`: register value on reset.
- `clock` in 1: rising-edge clock.
- `preset_` in 1: reset, asynchronous, active-low.
- `req` in N: request lines, one per requester.
- `j` in N*W: J masks; requester i uses bits [i*W +: W].
- `k` in N*W: K masks; requester i uses bits [i*W +: W].
- `ack` out N: acknowledge lines, one-hot or zero.
- `q` out W: shared register contents.
- `busy` out 1: high when the FSM is not in IDLE.
- `gnt_id` out clog2(N) (min 1): index of the current or last granted requester.

## Operation
- Reset (preset_ low, async):
  - q=INIT, ack=0, busy=0, gnt_id=0.
  - Round-robin pointer ptr=0; state IDLE.
  - Takes effect immediately, even mid-transaction; any grant in progress is abandoned with no update.
- FSM states: IDLE, APPLY, ACK.
- IDLE:
  - Stays here while req==0.
  - If any req bit is 1: g = first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Latches gnt_id<=g and goes to APPLY.
- APPLY (one cycle):
  - Per bit: q <= (~q & j_g) | (q & ~k_g).
  - j=0,k=0 hold; j=1,k=0 set; j=0,k=1 clear; j=1,k=1 toggle.
  - Sets ack[g]<=1 and goes to ACK.
  - j_g/k_g are sampled at this edge only.
  - The update is applied even if req[g] has already dropped.
- ACK:
  - Holds ack[g]=1 while req[g]=1.
  - When req[g]=0 is sampled: ack<=0, ptr<=(g+1) mod N, state IDLE.
- Requesters must hold j/k stable from req rise until ack is seen, and must not raise req again until ack returns to 0.
- Other requesters' req lines are ignored outside IDLE; they stay pending and are not lost.
- q changes only at the APPLY edge or on reset.

## Timing
- Cycle 0: req[i] rises, sampled at edge E0.
- Edge E0: state becomes APPLY.
- Edge E1: q updated, ack[i]=1. Request-to-update latency is 2 edges.
- Earliest release: req drops before E2, ack=0 after E2.
- Minimum transaction is 3 cycles. Back-to-back grants: the next IDLE arbitration happens at E3, so with continuous demand one grant every 3 cycles.
- Simultaneous requests: exactly one grant per transaction. With all N requesting, each is served once in N transactions, in order ptr, ptr+1, …
- N=1: the pointer stays 0 and the block behaves as a handshaked JK register.
- All outputs are registered. busy and ack have no combinational path from req.

## Configuration
- `JK_ARB_FIXED_PRIO_EN` defined: fixed priority; the lowest set req index always wins. ptr is not implemented and gnt_id behaves as before.
- Not defined (default): round-robin as described above.

## Test plan
- Reset: preset_ low mid-ACK with q=8'h5A → q=8'h00, ack=0, busy=0 immediately, without waiting for a clock edge. After release, a fresh req[0] is served normally.
- Single command: req[1] with j=8'h0F, k=8'hF0 on q=8'hAA.
  - q=8'h0F after E1.
  - ack[1] high from E1 until the edge after req[1] drops.
  - busy high E0..release.
- Toggle/hold: req[2] with j=k=8'hFF on q=8'h3C → q=8'hC3. Then j=k=8'h00 → q stays 8'hC3, ack still cycles.
- Round-robin: req=4'b1111 held, each requester dropping req one cycle after its ack.
  - Grant order 0,1,2,3,0.
  - One grant per 3 cycles minimum.
  - Never two ack bits high at once.
- Fixed priority (`JK_ARB_FIXED_PRIO_EN` defined): the same stimulus grants 0 repeatedly while req[0] re-requests; req[3] is granted only once req[2:0]=0.
- Protocol edge: req[0] dropped during APPLY → update still applied, ack[0] high for exactly one cycle, return to IDLE.
